// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencer
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  // Each request holds its own stage and everything upstream of it.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall request / exception / redirect bundle between core and sequencer
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic               stallreq_if;
  logic               stallreq_id;
  logic               stallreq_ex;
  logic               stallreq_mem;
  logic [31:0]        excepttype;
  logic [31:0]        cp0_epc;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        new_pc;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    output stall, flush, new_pc
  );

endinterface

// File: rtl/pipe_stall_mon.sv
// rtl/pipe_stall_mon.sv - stall timeout detection plus stall and flush performance counters
module pipe_stall_mon #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_active,
  input  logic             i_pc_stall,
  input  logic             i_flush,
  output logic             o_stall_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [15:0]      o_flush_count
);

  localparam int              TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0]  r_to_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [15:0]      r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt       <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      // Counter is frozen while halted so a debug pause does not mask a hang.
      if (i_active) begin
        if (i_flush || !i_pc_stall) begin
          r_to_cnt <= '0;
        end else if (r_to_cnt == TO_LAST) begin
          r_timeout <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
        if (i_pc_stall) begin
          r_stall_cycles <= r_stall_cycles + 1'b1;
        end
      end
      if (i_flush) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign o_stall_timeout = r_timeout;
  assign o_stall_cycles  = r_stall_cycles;
  assign o_flush_count   = r_flush_count;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with debug halt and single-step
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          TIMEOUT    = 1024,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       pipe,
  input  logic             i_dbg_halt_req,
  input  logic             i_dbg_step,
  output logic             o_halted,
  output logic             o_stall_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [15:0]      o_flush_count
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_halted;
  logic [STALL_W-1:0] w_base_stall;
  logic [STALL_W-1:0] w_stall;
  logic               w_flush;
  logic [31:0]        w_new_pc;

  always_comb begin
    w_base_stall = STALL_NONE;
    if (pipe.stallreq_mem)     w_base_stall = STALL_MEM;
    else if (pipe.stallreq_ex) w_base_stall = STALL_EX;
    else if (pipe.stallreq_id) w_base_stall = STALL_ID;
    else if (pipe.stallreq_if) w_base_stall = STALL_IF;
  end

  // HALT ignores exceptions: the frozen MEM stage would keep re-flushing.
  always_comb begin
    w_stall  = STALL_NONE;
    w_flush  = 1'b0;
    w_new_pc = '0;
    if (!rst) begin
      if (r_state == ST_HALT) begin
        w_stall = STALL_ALL;
      end else if (pipe.excepttype != '0) begin
        w_flush  = 1'b1;
        w_new_pc = (pipe.excepttype == EXC_ERET) ? pipe.cp0_epc : EXC_VECTOR;
      end else begin
        w_stall = w_base_stall;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_dbg_halt_req) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (!i_dbg_halt_req) w_state_nxt = ST_RUN;
        else if (i_dbg_step) w_state_nxt = ST_STEP;
      end
      ST_STEP: begin
        // A step ends once the PC is free to advance or the pipe is flushed.
        if (!w_stall[0] || w_flush) begin
          w_state_nxt = i_dbg_halt_req ? ST_HALT : ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
    end
  end

  pipe_stall_mon #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_stall_mon (
    .clk             (clk),
    .rst             (rst),
    .i_active        (r_state != ST_HALT),
    .i_pc_stall      (w_stall[0]),
    .i_flush         (w_flush),
    .o_stall_timeout (o_stall_timeout),
    .o_stall_cycles  (o_stall_cycles),
    .o_flush_count   (o_flush_count)
  );

  assign pipe.stall  = w_stall;
  assign pipe.flush  = w_flush;
  assign pipe.new_pc = w_new_pc;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        dbg_halt_req;
  logic        dbg_step;
  logic        halted;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  pipe_ctrl_if u_if();

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .TIMEOUT    (TMO),
    .CNT_W      (32)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .pipe            (u_if),
    .i_dbg_halt_req  (dbg_halt_req),
    .i_dbg_step      (dbg_step),
    .o_halted        (halted),
    .o_stall_timeout (stall_timeout),
    .o_stall_cycles  (stall_cycles),
    .o_flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_halt;
  bit          m_step;
  int          m_run;
  bit          m_to;
  logic [31:0] m_scyc;
  logic [15:0] m_fcnt;

  function automatic logic [5:0] exp_stall();
    int n;
    if (rst) return 6'd0;
    if (m_halt) return 6'h3f;
    if (u_if.excepttype != 0) return 6'd0;
    n = u_if.stallreq_mem ? 5 : u_if.stallreq_ex ? 4 : u_if.stallreq_id ? 3 : u_if.stallreq_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  function automatic logic exp_flush();
    return !rst && !m_halt && (u_if.excepttype != 0);
  endfunction

  function automatic logic [31:0] exp_new_pc();
    if (!exp_flush()) return 32'd0;
    return (u_if.excepttype == 32'he) ? u_if.cp0_epc : 32'h20;
  endfunction

  task automatic clear_inputs();
    u_if.stallreq_if  = 0;
    u_if.stallreq_id  = 0;
    u_if.stallreq_ex  = 0;
    u_if.stallreq_mem = 0;
    u_if.excepttype   = 0;
    u_if.cp0_epc      = 0;
    dbg_halt_req      = 0;
    dbg_step          = 0;
  endtask

  task automatic advance();
    logic [5:0] s;
    logic       f;
    s = exp_stall();
    f = exp_flush();
    @(posedge clk);
    if (rst) begin
      m_halt = 0; m_step = 0; m_run = 0; m_to = 0; m_scyc = 0; m_fcnt = 0;
    end else begin
      if (!m_halt) begin
        if (s[0]) begin
          m_run++;
          m_scyc++;
        end else begin
          m_run = 0;
        end
        if (m_run >= TMO) m_to = 1;
      end
      if (f) m_fcnt++;
      if (m_halt) begin
        if (!dbg_halt_req) m_halt = 0;
        else if (dbg_step) begin
          m_halt = 0;
          m_step = 1;
        end
      end else if (m_step) begin
        if (!(s[0] && !f)) begin
          m_step = 0;
          m_halt = dbg_halt_req;
        end
      end else begin
        m_halt = dbg_halt_req;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    u_if.stallreq_mem = 1;
    u_if.excepttype = 32'h8;
    #1;
    n_tests++;
    if (u_if.stall !== 6'd0 || u_if.flush !== 1'b0 || u_if.new_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_comb stall=%b flush=%b new_pc=%h required 0/0/0", u_if.stall, u_if.flush, u_if.new_pc);
    end
    advance();
    advance();
    rst = 0;
    clear_inputs();
    #1;
    n_tests++;
    if (halted !== 1'b0 || stall_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_regs halted=%b to=%b scyc=%0d fcnt=%0d required all 0", halted, stall_timeout, stall_cycles, flush_count);
    end
  endtask

  task automatic test_stall_priority();
    u_if.stallreq_id = 1;
    #1;
    n_tests++;
    if (u_if.stall !== 6'b000111) begin
      n_fail++;
      $display("FAIL stall_id got=%b required=%b", u_if.stall, 6'b000111);
    end
    advance();
    n_tests++;
    if (stall_cycles !== 32'd1) begin
      n_fail++;
      $display("FAIL stall_cycles_1 got=%0d required=1", stall_cycles);
    end
    u_if.stallreq_mem = 1;
    #1;
    n_tests++;
    if (u_if.stall !== 6'b011111) begin
      n_fail++;
      $display("FAIL stall_mem got=%b required=%b", u_if.stall, 6'b011111);
    end
    advance();
    n_tests++;
    if (stall_cycles !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_cycles_2 got=%0d required=2", stall_cycles);
    end
    clear_inputs();
    u_if.stallreq_ex = 1;
    u_if.stallreq_if = 1;
    #1;
    n_tests++;
    if (u_if.stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL stall_ex got=%b required=%b", u_if.stall, 6'b001111);
    end
    clear_inputs();
    advance();
  endtask

  task automatic test_exception();
    u_if.excepttype  = 32'h8;
    u_if.stallreq_ex = 1;
    #1;
    n_tests++;
    if (u_if.flush !== 1'b1 || u_if.stall !== 6'd0 || u_if.new_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL exc_syscall flush=%b stall=%b new_pc=%h required 1/000000/00000020", u_if.flush, u_if.stall, u_if.new_pc);
    end
    advance();
    n_tests++;
    if (flush_count !== 16'd1) begin
      n_fail++;
      $display("FAIL flush_count got=%0d required=1", flush_count);
    end
    u_if.excepttype = 32'he;
    u_if.cp0_epc    = 32'h100;
    #1;
    n_tests++;
    if (u_if.new_pc !== 32'h100 || u_if.flush !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_eret new_pc=%h flush=%b required 00000100/1", u_if.new_pc, u_if.flush);
    end
    advance();
    clear_inputs();
    #1;
    n_tests++;
    if (u_if.new_pc !== 32'd0 || flush_count !== 16'd2) begin
      n_fail++;
      $display("FAIL exc_clear new_pc=%h fcnt=%0d required 0/2", u_if.new_pc, flush_count);
    end
  endtask

  task automatic test_halt();
    dbg_halt_req = 1;
    advance();
    n_tests++;
    if (halted !== 1'b1 || u_if.stall !== 6'h3f) begin
      n_fail++;
      $display("FAIL halt_enter halted=%b stall=%b required 1/111111", halted, u_if.stall);
    end
    u_if.excepttype = 32'h8;
    #1;
    n_tests++;
    if (u_if.flush !== 1'b0 || u_if.new_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_exc flush=%b new_pc=%h required 0/0", u_if.flush, u_if.new_pc);
    end
    advance();
    clear_inputs();
    advance();
    n_tests++;
    if (halted !== 1'b0 || u_if.stall !== 6'd0) begin
      n_fail++;
      $display("FAIL halt_exit halted=%b stall=%b required 0/000000", halted, u_if.stall);
    end
  endtask

  task automatic test_step();
    dbg_halt_req = 1;
    advance();
    dbg_step = 1;
    u_if.stallreq_ex = 1;
    advance();
    dbg_step = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (u_if.stall !== 6'b001111 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL step_cycle%0d stall=%b halted=%b required 001111/0", k, u_if.stall, halted);
      end
      advance();
    end
    u_if.stallreq_ex = 0;
    #1;
    n_tests++;
    if (u_if.stall !== 6'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL step_last stall=%b halted=%b required 000000/0", u_if.stall, halted);
    end
    advance();
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL step_return halted=%b required=1", halted);
    end
    clear_inputs();
    advance();
  endtask

  task automatic test_timeout();
    n_tests++;
    if (stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pre got=%b required=0", stall_timeout);
    end
    u_if.stallreq_if = 1;
    for (int k = 1; k <= TMO; k++) begin
      advance();
      n_tests++;
      if (stall_timeout !== (k == TMO)) begin
        n_fail++;
        $display("FAIL timeout_edge%0d got=%b required=%b", k, stall_timeout, (k == TMO));
      end
    end
    u_if.stallreq_if = 0;
    advance();
    advance();
    n_tests++;
    if (stall_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky got=%b required=1", stall_timeout);
    end
  endtask

  task automatic test_reset_mid_step();
    dbg_halt_req = 1;
    advance();
    dbg_step = 1;
    u_if.stallreq_mem = 1;
    advance();
    dbg_step = 0;
    #1;
    n_tests++;
    if (u_if.stall !== 6'b011111) begin
      n_fail++;
      $display("FAIL midstep_stall got=%b required=%b", u_if.stall, 6'b011111);
    end
    rst = 1;
    #1;
    n_tests++;
    if (u_if.stall !== 6'd0 || u_if.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL midstep_rst_comb stall=%b flush=%b required 0/0", u_if.stall, u_if.flush);
    end
    advance();
    rst = 0;
    clear_inputs();
    #1;
    n_tests++;
    if (halted !== 1'b0 || stall_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midstep_rst_regs halted=%b to=%b scyc=%0d fcnt=%0d required all 0", halted, stall_timeout, stall_cycles, flush_count);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) dbg_halt_req = ~dbg_halt_req;
      dbg_step          = ($urandom_range(0, 3) == 0);
      u_if.stallreq_if  = ($urandom_range(0, 2) == 0);
      u_if.stallreq_id  = ($urandom_range(0, 3) == 0);
      u_if.stallreq_ex  = ($urandom_range(0, 4) == 0);
      u_if.stallreq_mem = ($urandom_range(0, 5) == 0);
      u_if.cp0_epc      = $urandom;
      r = $urandom_range(0, 9);
      case (r)
        7:       u_if.excepttype = 32'he;
        8:       u_if.excepttype = 32'h8;
        9:       u_if.excepttype = $urandom | 32'h1;
        default: u_if.excepttype = 0;
      endcase
      #1;
      n_tests++;
      if (u_if.stall !== exp_stall() || u_if.flush !== exp_flush() || u_if.new_pc !== exp_new_pc()) begin
        n_fail++;
        $display("FAIL rand_comb c=%0d stall=%b/%b flush=%b/%b new_pc=%h/%h (got/required)",
                 c, u_if.stall, exp_stall(), u_if.flush, exp_flush(), u_if.new_pc, exp_new_pc());
      end
      n_tests++;
      if (halted !== m_halt || stall_timeout !== m_to || stall_cycles !== m_scyc || flush_count !== m_fcnt) begin
        n_fail++;
        $display("FAIL rand_regs c=%0d halted=%b/%b to=%b/%b scyc=%0d/%0d fcnt=%0d/%0d (got/required)",
                 c, halted, m_halt, stall_timeout, m_to, stall_cycles, m_scyc, flush_count, m_fcnt);
      end
      advance();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clk = 0;
    rst = 1;
    clear_inputs();
    m_halt = 0; m_step = 0; m_run = 0; m_to = 0; m_scyc = 0; m_fcnt = 0;
    test_reset();
    test_stall_priority();
    test_exception();
    test_halt();
    test_step();
    test_timeout();
    test_reset_mid_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It combines stall requests from IF, ID, EX and MEM into the per-register stall vector that drives pc_reg, if_id, id_ex, ex_mem and mem_wb. It turns MEM-stage exceptions into a flush plus redirect PC. A debug FSM adds halt and single-step, with stall-timeout detection and performance counters.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect address for all non-ERET exceptions
TIMEOUT, 1024, consecutive PC-stall cycles before stall_timeout sets (>=2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stallreq_if  in  1  instruction bus wait
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multi-cycle EX op (div, madd)
stallreq_mem  in  1  data bus wait
excepttype  in  32  MEM-stage exception code, 0 = none
cp0_epc  in  32  EPC from CP0
dbg_halt_req  in  1  level: request halt
dbg_step  in  1  pulse: advance one instruction while halted
stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold
flush  out  1  clear all pipeline registers this cycle
new_pc  out  32  redirect PC, valid when flush=1
halted  out  1  FSM in HALT
stall_timeout  out  1  sticky timeout flag
stall_cycles  out  CNT_W  count of cycles with stall[0]=1
flush_count  out  16  count of flushes

Behaviour:
- Reset: rst=1 at a clock edge sets state RUN and clears the timeout counter, stall_timeout, stall_cycles and flush_count. While rst=1, stall, flush and new_pc are forced to 0 combinationally.
- stall, flush and new_pc are combinational from the inputs and the state (0-cycle latency). All other outputs are registered.
- Base stall priority (first match wins):
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - otherwise -> 0
- Exception (excepttype!=0 in RUN or STEP): flush=1 and stall=0. Flush overrides every stall request.
  - new_pc = cp0_epc when excepttype==32'h0000_000e (ERET).
  - new_pc = EXC_VECTOR for any other nonzero code.
  - When flush=0, new_pc=0.
- FSM states: RUN, HALT, STEP.
  - RUN -> HALT when dbg_halt_req=1 at the edge. A flush in the same cycle still occurs, and HALT is entered on the next cycle.
  - HALT: stall=6'b111111, flush=0, and excepttype is ignored because the frozen MEM stage would otherwise re-flush.
    - dbg_halt_req=0 -> RUN.
    - Otherwise dbg_step=1 -> STEP.
    - dbg_step is ignored outside HALT.
  - STEP: base stall and flush logic apply.
    - Stays in STEP while stall[0]=1 and flush=0.
    - Otherwise exits to HALT if dbg_halt_req=1, else to RUN.
  - halted=1 exactly in HALT.
- Timeout counter (RUN and STEP only):
  - Increments on each cycle with stall[0]=1.
  - Clears on any cycle with stall[0]=0 or flush=1.
  - Holds its value in HALT.
  - When the count reaches TIMEOUT-1 while stall[0]=1, stall_timeout sets at that edge and stays set until reset. The counter saturates.
- stall_cycles increments on each RUN/STEP cycle with stall[0]=1 and wraps modulo 2^CNT_W.
- flush_count increments on each flush cycle and wraps at 16 bits.

Decomposition:
- Shared define file additions:
  - stall vector width
  - state encodings RUN/HALT/STEP
  - ERET code 32'h0000_000e
  - the exception code constants: interrupt 1, syscall 8, invalid instruction a, overflow c, trap d
- Sub-module: pipe_stall_mon, which holds the timeout counter, stall_cycles and flush_count.
- Stall/flush decode and the FSM stay in pipe_ctrl.

Test Plan:
1. Reset, then stallreq_id=1 alone -> stall=6'b000111 in the same cycle. Add stallreq_mem=1 -> stall=6'b011111. stall_cycles increments by 1 per cycle.
2. excepttype=32'h0000_0008 with stallreq_ex=1 -> flush=1, stall=0, new_pc=32'h0000_0020, flush_count=1 next cycle. excepttype=32'h0000_000e with cp0_epc=32'h0000_0100 -> new_pc=32'h0000_0100.
3. dbg_halt_req=1 -> halted=1 next cycle and stall=6'b111111. excepttype=8 while halted -> flush stays 0. dbg_halt_req=0 -> RUN.
4. While halted, dbg_step pulse with stallreq_ex held 3 cycles -> STEP for 4 cycles with stall=6'b001111 for the first 3 cycles. FSM then returns to HALT with dbg_halt_req still 1.
5. TIMEOUT=4 and stallreq_if held 4 cycles -> stall_timeout=1 after the 4th edge. It stays 1 after the request drops and clears only on rst.
6. Assert rst mid-STEP with stallreq_mem=1 -> stall=0 and flush=0 during reset. After reset: state RUN and all counters 0.
